// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
// Purpose : Bundles the signals around uart_tx_fifo. On one side is the
//           mem_ctl write and status path. On the other side is the uart_tx
//           start strobe, data byte and busy handshake.
// Modports:
//   slave  - the FIFO itself (drives status and the uart_tx strobe/data).
//   master - the surroundings (mem_ctl writes and flush, uart_tx busy).
// Signals :
//   wr_en, wr_data, flush           - push / discard requests from mem_ctl
//   full, empty, level, overflow    - registered status back to mem_ctl
//   uart_tx_en, uart_tx_data        - one-cycle start strobe and byte to uart_tx
//   uart_tx_busy                    - uart_tx frame in progress
//   drop_count                      - present only when UART_TX_FIFO_STATS_EN
//                                     is defined
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if #(
   parameter int DEPTH_LOG2 = 4
);
   logic                  wr_en;
   logic [7:0]            wr_data;
   logic                  flush;
   logic                  full;
   logic                  empty;
   logic [DEPTH_LOG2:0]   level;
   logic                  overflow;
   logic                  uart_tx_en;
   logic [7:0]            uart_tx_data;
   logic                  uart_tx_busy;
`ifdef UART_TX_FIFO_STATS_EN
   logic [7:0]            drop_count;
`endif

   modport slave (
      input  wr_en, wr_data, flush, uart_tx_busy,
      output full, empty, level, overflow, uart_tx_en, uart_tx_data
`ifdef UART_TX_FIFO_STATS_EN
      , output drop_count
`endif
   );

   modport master (
      output wr_en, wr_data, flush, uart_tx_busy,
      input  full, empty, level, overflow, uart_tx_en, uart_tx_data
`ifdef UART_TX_FIFO_STATS_EN
      , input drop_count
`endif
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Purpose : Byte FIFO between the mem_ctl UART data-register write strobe and
//           the uart_tx serializer. Writes are queued and do not wait for
//           uart_tx. A small FSM starts one uart_tx frame per queued byte.
// Ports   :
//   clk  - system clock; all logic updates on the rising edge
//   rst  - synchronous reset, active high
//   bus  - uart_tx_fifo_if.slave. It carries the mem_ctl write and flush
//          inputs, the registered full/empty/level/overflow status, and the
//          uart_tx_en/uart_tx_data/uart_tx_busy handshake.
// Options : Define UART_TX_FIFO_STATS_EN to add bus.drop_count. This is an
//           8-bit saturating count of rejected pushes, cleared by rst and by
//           flush.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int DEPTH      = 16,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_fifo_if.slave  bus
);

   localparam int LEVEL_W = DEPTH_LOG2 + 1;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
   localparam logic [LEVEL_W-1:0]    LEVEL_ONE = LEVEL_W'(1);
   localparam logic [LEVEL_W-1:0]    LEVEL_MAX = LEVEL_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_reg;
   logic [DEPTH_LOG2-1:0] rd_ptr_reg;
   logic [LEVEL_W-1:0]    level_reg;
   logic [LEVEL_W-1:0]    level_next;
   logic                  full_reg;
   logic                  empty_reg;
   logic                  overflow_reg;
   logic                  tx_en_reg;
   logic [7:0]            tx_data_reg;
   state_t                state_reg;
   state_t                state_next;
   logic [1:0]            tmo_reg;
   logic [1:0]            tmo_next;
   logic                  push;
   logic                  drop;
   logic                  launch;

   // full is the registered flag. A push against a full FIFO is dropped even
   // when a launch frees a slot in the same cycle. flush overrides everything.
   assign push = bus.wr_en && !full_reg && !bus.flush;
   assign drop = bus.wr_en &&  full_reg && !bus.flush;

   // ---------------------------------------------------------------------------
   // Launch FSM: next state and launch decision
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      tmo_next   = tmo_reg;
      launch     = 1'b0;
      case (state_reg)
         IDLE: begin
            // A flush in the same cycle suppresses the launch.
            if (!empty_reg && !bus.uart_tx_busy && !bus.flush) begin
               launch     = 1'b1;
               state_next = WAIT_BUSY;
               tmo_next   = 2'd0;
            end
         end
         WAIT_BUSY: begin
            // If uart_tx never reports busy, treat the byte as sent after
            // three cycles so the queue cannot lock up.
            if (bus.uart_tx_busy) begin
               state_next = WAIT_DONE;
            end else if (tmo_reg == 2'd2) begin
               state_next = IDLE;
            end else begin
               tmo_next = tmo_reg + 2'd1;
            end
         end
         WAIT_DONE: begin
            if (!bus.uart_tx_busy) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      level_next = level_reg;
      case ({push, launch})
         2'b10:   level_next = level_reg + LEVEL_ONE;
         2'b01:   level_next = level_reg - LEVEL_ONE;
         default: level_next = level_reg;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Storage: plain array write, registered read through tx_data_reg
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= bus.wr_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Pointers, level and status flags
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         full_reg     <= 1'b0;
         empty_reg    <= 1'b1;
         overflow_reg <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (launch) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         level_reg <= level_next;
         full_reg  <= (level_next == LEVEL_MAX);
         empty_reg <= (level_next == '0);
         if (drop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // FSM state and uart_tx outputs. flush does not touch these, so a frame
   // already in flight completes normally.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         tmo_reg     <= 2'd0;
         tx_en_reg   <= 1'b0;
         tx_data_reg <= 8'h00;
      end else begin
         state_reg <= state_next;
         tmo_reg   <= tmo_next;
         tx_en_reg <= launch;
         if (launch) begin
            tx_data_reg <= mem[rd_ptr_reg];
         end
      end
   end

   assign bus.full         = full_reg;
   assign bus.empty        = empty_reg;
   assign bus.level        = level_reg;
   assign bus.overflow     = overflow_reg;
   assign bus.uart_tx_en   = tx_en_reg;
   assign bus.uart_tx_data = tx_data_reg;

`ifdef UART_TX_FIFO_STATS_EN
   logic [7:0] drop_count_reg;

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         drop_count_reg <= 8'h00;
      end else if (drop && (drop_count_reg != 8'hFF)) begin
         drop_count_reg <= drop_count_reg + 8'h01;
      end
   end

   assign bus.drop_count = drop_count_reg;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Purpose : Self-checking bench for uart_tx_fifo. Each accepted byte is queued
//           as an expected value when it is pushed. The byte is popped and
//           compared when uart_tx_en pulses. A simple uart_tx model raises
//           busy for frame_len cycles after each start strobe, or never raises
//           it when frame_len is 0.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_fifo;

   logic clk;
   logic rst;

   uart_tx_fifo_if #(.DEPTH_LOG2(4)) bus ();

   uart_tx_fifo #(.DEPTH(16), .DEPTH_LOG2(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         tests_run  = 0;
   int         tests_fail = 0;
   logic [7:0] sb [$];
   int         en_total   = 0;
   int         en_times [$];
   int         cyc        = 0;
   logic       en_prev    = 1'b0;

   // uart_tx model
   int   frame_len = 0;
   int   busy_cnt  = 0;
   logic busy_hold = 1'b0;
   assign bus.uart_tx_busy = busy_hold | (busy_cnt != 0);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         busy_cnt <= 0;
      end else if (bus.uart_tx_en && frame_len > 0) begin
         busy_cnt <= frame_len;
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor: one line per transmitted byte, compared against the scoreboard
   always @(negedge clk) begin
      if (en_prev) begin
         check_val("en_width", bus.uart_tx_en, 1'b0);
      end
      if (bus.uart_tx_en && !en_prev) begin
         en_total++;
         en_times.push_back(cyc);
         if (sb.size() == 0) begin
            check_val("spurious_en", bus.uart_tx_en, 1'b0);
         end else begin
            logic [7:0] exp_b;
            exp_b = sb.pop_front();
            $display("[TB] tx byte %02h (expected %02h) at cycle %0d", bus.uart_tx_data, exp_b, cyc);
            check_val("tx_data", bus.uart_tx_data, exp_b);
         end
      end
      en_prev = bus.uart_tx_en;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b, input bit accept);
      bus.wr_en   = 1'b1;
      bus.wr_data = b;
      if (accept) sb.push_back(b);
      tick();
      bus.wr_en   = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int stable = 0;
      int n = 0;
      while (stable < 6 && n < budget) begin
         tick();
         n++;
         if (sb.size() == 0 && bus.empty && !bus.uart_tx_busy) stable++;
         else stable = 0;
      end
      check_val("drain_done", (stable >= 6), 1'b1);
   endtask

   initial begin
      int en_before;
      int guard;
      logic [7:0] v;

      bus.wr_en   = 1'b0;
      bus.wr_data = 8'h00;
      bus.flush   = 1'b0;
      rst         = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state
      check_val("rst_empty",    bus.empty,        1'b1);
      check_val("rst_full",     bus.full,         1'b0);
      check_val("rst_level",    bus.level,        5'd0);
      check_val("rst_overflow", bus.overflow,     1'b0);
      check_val("rst_en",       bus.uart_tx_en,   1'b0);
      check_val("rst_data",     bus.uart_tx_data, 8'h00);
`ifdef UART_TX_FIFO_STATS_EN
      check_val("rst_drops",    bus.drop_count,   8'h00);
`endif

      // 1: single byte, launch one cycle after the push edge
      frame_len = 0;
      push_byte(8'h55, 1'b1);
      check_val("t1_level_after_push", bus.level, 5'd1);
      check_val("t1_empty_after_push", bus.empty, 1'b0);
      check_val("t1_en_not_yet",       bus.uart_tx_en, 1'b0);
      tick();
      check_val("t1_en",    bus.uart_tx_en,   1'b1);
      check_val("t1_data",  bus.uart_tx_data, 8'h55);
      check_val("t1_level", bus.level,        5'd0);
      check_val("t1_empty", bus.empty,        1'b1);
      wait_drain(50);

      // 3: overflow with busy held
      busy_hold = 1'b1;
      en_before = en_total;
      for (int i = 0; i < 17; i++) begin
         push_byte(8'hC0 + 8'(i), (i < 16));
      end
      check_val("t3_full",     bus.full,     1'b1);
      check_val("t3_level",    bus.level,    5'd16);
      check_val("t3_overflow", bus.overflow, 1'b1);
      check_val("t3_no_en",    en_total - en_before, 0);
`ifdef UART_TX_FIFO_STATS_EN
      check_val("t3_drops",    bus.drop_count, 8'h01);
`endif
      busy_hold = 1'b0;
      frame_len = 3;
      wait_drain(400);
      check_val("t3_en_count", en_total - en_before, 16);
      check_val("t3_overflow_sticky", bus.overflow, 1'b1);

      // 2: burst of 16 under 20-cycle frames
      frame_len = 20;
      en_before = en_total;
      for (int i = 1; i <= 16; i++) begin
         push_byte(8'(i), 1'b1);
      end
      wait_drain(1000);
      check_val("t2_en_count", en_total - en_before, 16);

      // 4: 40 bytes through the ring, pushing whenever not full
      frame_len = 2;
      en_before = en_total;
      for (int i = 0; i < 40; i++) begin
         guard = 0;
         while (bus.full && guard < 100) begin
            tick();
            guard++;
         end
         check_val("t4_full_wait", (guard < 100), 1'b1);
         v = 8'($urandom_range(0, 255));
         push_byte(v, 1'b1);
      end
      wait_drain(1000);
      check_val("t4_en_count", en_total - en_before, 40);
      check_val("t4_empty",    bus.empty, 1'b1);
      check_val("t4_level",    bus.level, 5'd0);

      // 5: flush mid-frame together with a push of 8'hAA
      frame_len = 20;
      push_byte(8'h77, 1'b1);
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         push_byte(8'hA1 + 8'(i), 1'b0);
      end
      check_val("t5_level_pre",    bus.level,    5'd5);
      check_val("t5_overflow_pre", bus.overflow, 1'b1);
      en_before = en_total;
      bus.flush   = 1'b1;
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'hAA;
      tick();
      bus.flush = 1'b0;
      bus.wr_en = 1'b0;
      check_val("t5_level",    bus.level,    5'd0);
      check_val("t5_empty",    bus.empty,    1'b1);
      check_val("t5_overflow", bus.overflow, 1'b0);
      check_val("t5_busy_on",  bus.uart_tx_busy, 1'b1);
`ifdef UART_TX_FIFO_STATS_EN
      check_val("t5_drops",    bus.drop_count, 8'h00);
`endif
      repeat (40) tick();
      check_val("t5_no_en", en_total - en_before, 0);

      // 6: busy never asserts, FSM times out and sends the next byte
      frame_len = 0;
      en_times.delete();
      push_byte(8'h3C, 1'b1);
      push_byte(8'hC3, 1'b1);
      wait_drain(100);
      check_val("t6_pulses", en_times.size(), 2);
      if (en_times.size() == 2) begin
         check_val("t6_gap", en_times[1] - en_times[0], 4);
      end

      // 6b: reset during WAIT_DONE
      frame_len = 20;
      push_byte(8'h11, 1'b1);
      push_byte(8'h22, 1'b1);
      push_byte(8'h33, 1'b1);
      repeat (3) tick();
      check_val("t6_busy_mid", bus.uart_tx_busy, 1'b1);
      rst = 1'b1;
      tick();
      sb.delete();
      rst = 1'b0;
      check_val("t6_rst_empty",    bus.empty,        1'b1);
      check_val("t6_rst_full",     bus.full,         1'b0);
      check_val("t6_rst_level",    bus.level,        5'd0);
      check_val("t6_rst_overflow", bus.overflow,     1'b0);
      check_val("t6_rst_en",       bus.uart_tx_en,   1'b0);
      check_val("t6_rst_data",     bus.uart_tx_data, 8'h00);
      en_before = en_total;
      repeat (30) tick();
      check_val("t6_quiet", en_total - en_before, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
      $finish;
   end

endmodule
